// File: rtl/gpio_hex_bridge.sv
// GPIO bridge: shows the CPU's GPIO output word in decimal on eight active-low
// seven-segment digits, and returns the synchronized slide switches as the
// GPIO input word. An iterative double-dabble converter handles the binary to
// BCD conversion, one bit per clock.
module gpio_hex_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int SW_WIDTH    = 18,
    parameter int BIN_BITS    = 27
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic [31:0]         gpio_out,
    input  logic [SW_WIDTH-1:0] sw,
    output logic [31:0]         gpio_in,
    output logic [6:0]          hex0,
    output logic [6:0]          hex1,
    output logic [6:0]          hex2,
    output logic [6:0]          hex3,
    output logic [6:0]          hex4,
    output logic [6:0]          hex5,
    output logic [6:0]          hex6,
    output logic [6:0]          hex7,
    output logic                busy
);

    localparam int          CNT_W   = $clog2(BIN_BITS);
    localparam logic [31:0] MAX_DEC = 32'd99_999_999;
    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;
    localparam logic [6:0]  SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Segment pattern for one decimal digit, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    logic [SW_WIDTH-1:0] sync_q [SYNC_STAGES];

    state_t              state_q;
    logic [31:0]         last_val_q;
    logic                ovf_q;
    logic [BIN_BITS-1:0] bin_q;
    logic [31:0]         bcd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [6:0]          hex_q [8];

    logic [31:0]         bcd_adj_d;
    logic [6:0]          seg_d [8];
    logic                lead_d;

    // Switch synchronizer chain; the last stage feeds the CPU.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value, giving a true SYNC_STAGES-deep chain.
            sync_q[0] <= sw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign gpio_in = {{(32-SW_WIDTH){1'b0}}, sync_q[SYNC_STAGES-1]};

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        // NOTE: the default assignment up front keeps this block latch-free.
        bcd_adj_d = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Segment image of the finished BCD value, with leading-zero blanking.
    always_comb begin
        lead_d = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            seg_d[i] = SEG_BLANK;
            if (ovf_q) begin
                seg_d[i] = SEG_DASH;
            end else if (lead_d && bcd_q[4*i +: 4] == 4'd0 && i != 0) begin
                seg_d[i] = SEG_BLANK;
            end else begin
                lead_d   = 1'b0;
                seg_d[i] = seg7(bcd_q[4*i +: 4]);
            end
        end
    end

    // Conversion FSM: capture on change, shift BIN_BITS times, then load the display.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= IDLE;
            last_val_q <= '0;
            ovf_q      <= 1'b0;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            hex_q[0]   <= SEG_ZERO;
            for (int i = 1; i < 8; i++) hex_q[i] <= SEG_BLANK;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gpio_out != last_val_q) begin
                        last_val_q <= gpio_out;
                        ovf_q      <= (gpio_out > MAX_DEC);
                        bin_q      <= gpio_out[BIN_BITS-1:0];
                        bcd_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= {bcd_adj_d[30:0], bin_q[BIN_BITS-1]};
                    bin_q <= {bin_q[BIN_BITS-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BIN_BITS - 1)) state_q <= DONE;
                end
                DONE: begin
                    for (int i = 0; i < 8; i++) hex_q[i] <= seg_d[i];
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
    assign hex6 = hex_q[6];
    assign hex7 = hex_q[7];

endmodule

// File: doc/gpio_hex_bridge.md
Name: gpio_hex_bridge

Overview:
- Board-side peripheral at the far end of the CPU's GPIO register pair.
- Consumes the CPU's 32-bit GPIO output word and shows it in decimal on eight active-low seven-segment digits, using an iterative double-dabble converter.
- Produces the CPU's GPIO input word from synchronized slide switches.

Parameters:
SYNC_STAGES, 2, flip-flop stages on the switch input path (minimum 2)
SW_WIDTH, 18, number of slide switches; zero-extended into gpio_in
BIN_BITS, 27, binary width fed to the converter (2^27 > 99,999,999)

Ports:
clk  input  1  system clock
res_n  input  1  asynchronous active-low reset
gpio_out  input  32  GPIO output word from CPU (value to display)
sw  input  SW_WIDTH  raw asynchronous slide switches
gpio_in  output  32  GPIO input word to CPU
hex0..hex7  output  7 each  digit segments, active-low, bit order {g,f,e,d,c,b,a}; hex0 = least significant digit
busy  output  1  high while a conversion is in progress

Behaviour:
- Reset (res_n low, asynchronous; applies immediately, including mid-conversion):
  - sync flops = 0, gpio_in = 0
  - state = IDLE, busy = 0, last_val = 0
  - hex0 = 7'b1000000 ("0"); hex1..hex7 = 7'h7F (blank)
- Switch path:
  - sw passes through SYNC_STAGES flops.
  - gpio_in = {zeros, sw_sync}.
  - A change on sw appears on gpio_in exactly SYNC_STAGES rising edges later.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If gpio_out != last_val at a rising edge E:
    - last_val <= gpio_out
    - ovf <= (gpio_out > 99_999_999)
    - bin <= gpio_out[BIN_BITS-1:0], bcd <= 0, cnt <= 0
    - go to SHIFT
  - Otherwise stay in IDLE.
- SHIFT: one iteration per edge.
  - Every BCD nibble >= 5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - cnt increments.
  - After the BIN_BITS-th iteration (edge E+27) go to DONE.
- DONE (edge E+28):
  - Segment registers load from bcd, or from all-dash if ovf.
  - Go to IDLE.
- Timing:
  - busy = (state != IDLE); busy is high after edge E through edge E+28.
  - Display latency: 28 edges after the capture edge.
- gpio_out changes during SHIFT/DONE are ignored.
  - On return to IDLE, the comparison against last_val starts a new conversion, so the final gpio_out value is always displayed.
  - Intermediate values may be skipped.
- Overflow: gpio_out > 99,999,999 displays a dash (7'b0111111) on all eight digits, with identical latency.
- Leading-zero blanking:
  - Digits above the most significant nonzero digit are 7'h7F.
  - A value of 0 shows "0" on hex0 only.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Segment outputs are registered and change only at DONE or reset; they never glitch during SHIFT.

Test Plan:
1. Assert res_n low mid-SHIFT with gpio_out=32'd500 -> immediately busy=0, hex0=1000000, hex1..7=7F, gpio_in=0. After release, a new conversion starts and displays 500.
2. gpio_out 0->32'd12345678 -> busy high 28 cycles. At E+28: hex7..hex0 = 1,2,3,4,5,6,7,8 codes.
3. gpio_out=32'd907 -> hex2=0010000, hex1=1000000, hex0=1111000, hex3..7=7F.
4. Overflow boundary:
   - gpio_out=32'd99999999 -> all digits 0010000.
   - then 32'd100000000 -> all digits 0111111.
   - then 32'hFFFFFFFF -> all digits 0111111.
5. gpio_out=5, then 42 set 10 cycles after capture -> 5 displayed at E+28. Second conversion starts at the next IDLE edge; 42 (hex1=0011001, hex0=0100100) shows 29 edges after that. Intermediate toggles 7->9->42 within one conversion show only 42.
6. sw=18'h2ABCD applied -> gpio_in still 0 after 1 edge; gpio_in=32'h0002ABCD after 2 edges.
